memory_map_io: RTL and testbench
================================

# memory_map_io

Parametrised memory-mapped data-memory and I/O block for the Hack-style CPU. It replaces the fixed RAM-plus-sixteen-register map with a configurable map containing:
- a RAM window of configurable depth;
- a configurable count of I/O registers;
- a synchronised, optionally debounced button input with sticky rising-edge flags.

The CPU drives `addressM`, `outM` and `writeM`, and samples `inM` in the same cycle.

## Interface
- `DATA_W`, 16: data word width.
- `ADDR_W`, 16: CPU address width.
- `RAM_DEPTH`, 3840: RAM words, mapped at address 0 .. `RAM_DEPTH`-1.
- `IO_BASE`, 16'h1000: address of I/O register 0; must be ≥ `RAM_DEPTH`.
- `IO_CNT`, 16: number of I/O registers, range 4..64.
- `BTN_W`, 2: button count, ≤ `DATA_W`.
- `LED_W`, 2: LED count, ≤ `DATA_W`.
- `DEB_CYCLES`, 50000: stable-sample count required for a debounced level change.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `writeM`  in  1  CPU write strobe.
- `addressM`  in  `ADDR_W`  CPU address.
- `outM`  in  `DATA_W`  CPU write data.
- `inM`  out  `DATA_W`  read data for `addressM`; combinational.
- `button`  in  `BTN_W`  raw asynchronous button pins.
- `leds`  out  `LED_W`  LED drive, equal to `IO[0][LED_W-1:0]`.

## Operation
Address decode:
- RAM hit: `addressM < RAM_DEPTH`.
- IO hit on index k: `IO_BASE ≤ addressM < IO_BASE+IO_CNT`, with k = `addressM-IO_BASE`.
- Any other address: no hit. Reads return 0; writes are ignored.

RAM:
- Write on `writeM` & RAM hit.
- Read is asynchronous (`inM` follows the address combinationally).

IO register map (k = index within the IO window):
- k=0, LED: read/write; all `DATA_W` bits are stored.
- k=1, BTN_LEVEL: read-only; zero-extended debounced button levels. Writes are ignored.
- k=2, BTN_EDGE: sticky rising-edge flags, one per button.
  - Bit b is set when debounced level b goes 0→1.
  - Write-1-to-clear: a write clears every bit where `outM` is 1.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- k=3 .. `IO_CNT`-1: general read/write registers.

Button path:
- Each button passes through a 2-flop synchroniser, then the debouncer.
- Debouncer: a per-button counter increments while the synchronised input differs from the debounced level and resets to 0 when they agree.
- On reaching `DEB_CYCLES`-1 the debounced level toggles and the counter clears.
- The counter width is $clog2(`DEB_CYCLES`); it never wraps.

Reset (`rst_n` low, asynchronous):
- Cleared: all IO registers, synchroniser flops, debounce counters, debounced levels and edge flags. `leds` = 0.
- RAM contents are not reset.
- Reset asserted mid-debounce discards any partial count.

## Timing
- Register/RAM write: takes effect at the rising edge where `writeM` is high. A read in the next cycle returns the new value.
- A read in the same cycle as a write returns the old value.
- `inM` is valid within the same cycle as `addressM`, with zero latency.
- Button to BTN_LEVEL latency:
  - with debounce: 2 sync cycles + `DEB_CYCLES` stable cycles;
  - without debounce: 2 cycles.
- BTN_EDGE bit sets on the same edge that BTN_LEVEL rises, so both are visible in the following cycle.
- Glitches shorter than `DEB_CYCLES` cycles produce no level change and no edge flag.

## Configuration
- Macro `MEMIO_DEBOUNCE_EN`.
- Defined: the counter debouncer is instantiated per button as described above.
- Undefined: debounced level = synchroniser output directly. No counters are built and `DEB_CYCLES` is unused. Edge flags still operate.

## Structure
- Package `memio_pkg` holds:
  - IO index constants `IO_LED`=0, `IO_BTN_LEVEL`=1, `IO_BTN_EDGE`=2, `IO_GP_FIRST`=3;
  - the default `IO_BASE`;
  - the address-decode result enum (`DEC_RAM`, `DEC_IO`, `DEC_NONE`).
- One sub-module, `button_debounce`: synchroniser plus debounce counter for a single button, parameter `DEB_CYCLES`, ports `clk`, `rst_n`, `din`, `level`, `rise`. Instantiated `BTN_W` times.

## Test plan
- Reset: hold `rst_n`=0, then release. Require `leds`=0 and reads of `IO_BASE`+0..+`IO_CNT`-1 = 0.
- RAM: write 16'hA5A5 to address 0 and 16'h1234 to address 3839. Require readback of both values. A read at address 3840 returns 0.
- IO/LED: write 16'h0003 to `IO_BASE`. Require `leds`=2'b11 next cycle. Write 16'hBEEF to `IO_BASE`+15 and require readback 16'hBEEF. A write to `IO_BASE`+1 leaves BTN_LEVEL unchanged.
- Debounce (macro on, `DEB_CYCLES`=8):
  - `button[0]` high for 5 cycles then low → BTN_LEVEL=0 and BTN_EDGE=0.
  - `button[0]` held high for 12 cycles → BTN_LEVEL=16'h0001 and BTN_EDGE=16'h0001 by cycle 11.
- W1C and collision:
  - With BTN_EDGE=16'h0003, write 16'h0001 → 16'h0002.
  - Write 16'h0002 in the same cycle as a new `button[1]` debounced rise → bit 1 remains 1.
- Reset mid-debounce: assert `rst_n`=0 after 4 of 8 stable cycles, then release with the button still high. Require BTN_LEVEL to rise only after a full 2+8 cycles.

Source files
------------

// File: rtl/memory_map_io_pkg.sv
// Shared constants and types for the Hack-style memory/IO map.
// IO register indices, default IO window base, address-decode result.
package memio_pkg;

   localparam int IO_LED       = 0;
   localparam int IO_BTN_LEVEL = 1;
   localparam int IO_BTN_EDGE  = 2;
   localparam int IO_GP_FIRST  = 3;

   localparam int DEF_IO_BASE  = 'h1000;

   typedef enum logic [1:0] {
      DEC_RAM,
      DEC_IO,
      DEC_NONE
   } dec_t;

endpackage

// File: rtl/memory_map_io_button_debounce.sv
// Single-button 2-flop synchroniser plus optional counter debouncer.
// Build option: MEMIO_DEBOUNCE_EN enables the counter; otherwise level = synchroniser output.
module button_debounce #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise
);

   logic r_sync0;
   logic r_sync1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync0 <= 1'b0;
         r_sync1 <= 1'b0;
      end else begin
         r_sync0 <= din;
         r_sync1 <= r_sync0;
      end
   end

`ifdef MEMIO_DEBOUNCE_EN
   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             w_done;

   // Toggle once DEB_CYCLES consecutive differing samples have been seen.
   assign w_done = (r_sync1 != r_level) && (r_cnt == CNT_W'(DEB_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (r_sync1 == r_level) begin
         r_cnt   <= '0;
      end else if (w_done) begin
         r_cnt   <= '0;
         r_level <= ~r_level;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign level = r_level;
   assign rise  = w_done & ~r_level;
`else
   assign level = r_sync1;
   assign rise  = r_sync0 & ~r_sync1;
`endif

endmodule

// File: rtl/memory_map_io.sv
// Memory-mapped data RAM plus IO register window (LED, button level/edge, GP regs).
// Build option: MEMIO_DEBOUNCE_EN selects the counter debouncer in button_debounce.
module memory_map_io
   import memio_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int RAM_DEPTH  = 3840,
   parameter int IO_BASE    = DEF_IO_BASE,
   parameter int IO_CNT     = 16,
   parameter int BTN_W      = 2,
   parameter int LED_W      = 2,
   parameter int DEB_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              writeM,
   input  logic [ADDR_W-1:0] addressM,
   input  logic [DATA_W-1:0] outM,
   output logic [DATA_W-1:0] inM,
   input  logic [BTN_W-1:0]  button,
   output logic [LED_W-1:0]  leds
);

   localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam int IDX_W  = (IO_CNT > 1) ? $clog2(IO_CNT) : 1;

   logic [DATA_W-1:0] r_ram [RAM_DEPTH];
   logic [DATA_W-1:0] r_io  [IO_CNT];
   logic [BTN_W-1:0]  r_edge;

   dec_t              w_dec;
   logic [ADDR_W-1:0] w_off;
   logic [IDX_W-1:0]  w_idx;
   logic [RAM_AW-1:0] w_ram_idx;
   logic              w_io_wr;
   logic [BTN_W-1:0]  w_edge_clr;
   logic [BTN_W-1:0]  w_level;
   logic [BTN_W-1:0]  w_rise;

   always_comb begin
      w_off     = addressM - ADDR_W'(IO_BASE);
      w_idx     = w_off[IDX_W-1:0];
      w_ram_idx = '0;
      if (addressM < ADDR_W'(RAM_DEPTH)) begin
         w_dec     = DEC_RAM;
         w_ram_idx = addressM[RAM_AW-1:0];
      end else if ((addressM >= ADDR_W'(IO_BASE)) && (w_off < ADDR_W'(IO_CNT))) begin
         w_dec = DEC_IO;
      end else begin
         w_dec = DEC_NONE;
      end
   end

   // Level and edge registers are never stored in r_io; their slots stay zero.
   assign w_io_wr = writeM && (w_dec == DEC_IO) &&
                    ((w_idx == IDX_W'(IO_LED)) || (w_idx >= IDX_W'(IO_GP_FIRST)));

   assign w_edge_clr = (writeM && (w_dec == DEC_IO) && (w_idx == IDX_W'(IO_BTN_EDGE)))
                       ? outM[BTN_W-1:0] : '0;

   always_ff @(posedge clk) begin
      if (writeM && (w_dec == DEC_RAM)) begin
         r_ram[w_ram_idx] <= outM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < IO_CNT; k++) begin
            r_io[k] <= '0;
         end
      end else if (w_io_wr) begin
         r_io[w_idx] <= outM;
      end
   end

   // Set has priority over a simultaneous write-1-to-clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_edge <= '0;
      end else begin
         r_edge <= (r_edge & ~w_edge_clr) | w_rise;
      end
   end

   for (genvar b = 0; b < BTN_W; b++) begin : g_btn
      button_debounce #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_btn (
         .clk  (clk),
         .rst_n(rst_n),
         .din  (button[b]),
         .level(w_level[b]),
         .rise (w_rise[b])
      );
   end

   always_comb begin
      inM = '0;
      case (w_dec)
         DEC_RAM: inM = r_ram[w_ram_idx];
         DEC_IO: begin
            if (w_idx == IDX_W'(IO_BTN_LEVEL)) begin
               inM = DATA_W'(w_level);
            end else if (w_idx == IDX_W'(IO_BTN_EDGE)) begin
               inM = DATA_W'(r_edge);
            end else begin
               inM = r_io[w_idx];
            end
         end
         default: inM = '0;
      endcase
   end

   assign leds = r_io[IO_LED][LED_W-1:0];

endmodule

// File: tb/tb_memory_map_io.sv
// Directed self-checking bench for memory_map_io; latencies follow MEMIO_DEBOUNCE_EN.
module tb_memory_map_io;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int IO_BASE = 'h1000;
   localparam int IO_CNT  = 16;
   localparam int DEB     = 8;
`ifdef MEMIO_DEBOUNCE_EN
   localparam int LAT     = 2 + DEB;
`else
   localparam int LAT     = 2;
`endif
   localparam logic [ADDR_W-1:0] A_LED   = 16'h1000;
   localparam logic [ADDR_W-1:0] A_LEVEL = 16'h1001;
   localparam logic [ADDR_W-1:0] A_EDGE  = 16'h1002;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              writeM;
   logic [ADDR_W-1:0] addressM;
   logic [DATA_W-1:0] outM;
   logic [DATA_W-1:0] inM;
   logic [1:0]        button;
   logic [1:0]        leds;

   int n_checks = 0;
   int n_errors = 0;

   memory_map_io #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .RAM_DEPTH (3840),
      .IO_BASE   (IO_BASE),
      .IO_CNT    (IO_CNT),
      .BTN_W     (2),
      .LED_W     (2),
      .DEB_CYCLES(DEB)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .writeM  (writeM),
      .addressM(addressM),
      .outM    (outM),
      .inM     (inM),
      .button  (button),
      .leds    (leds)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      addressM = a;
      outM     = d;
      writeM   = 1'b1;
      tick();
      writeM   = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
      addressM = a;
      #1;
      check(tag, 32'(inM), 32'(exp));
   endtask

   initial begin
      rst_n    = 1'b0;
      writeM   = 1'b0;
      addressM = '0;
      outM     = '0;
      button   = 2'b00;
      repeat (3) tick();
      check("leds_in_reset", 32'(leds), 32'h0);
      rst_n = 1'b1;
      tick();

      for (int k = 0; k < IO_CNT; k++) begin
         rd("io_reset", ADDR_W'(IO_BASE + k), 16'h0000);
      end
      check("leds_after_reset", 32'(leds), 32'h0);

      // RAM window and its boundary
      wr(16'd0, 16'hA5A5);
      wr(16'd3839, 16'h1234);
      rd("ram_0", 16'd0, 16'hA5A5);
      rd("ram_3839", 16'd3839, 16'h1234);
      rd("ram_3840_none", 16'd3840, 16'h0000);
      addressM = 16'd0;
      outM     = 16'h5555;
      writeM   = 1'b1;
      #1;
      check("ram_read_during_write_old", 32'(inM), 32'h0000A5A5);
      tick();
      writeM = 1'b0;
      rd("ram_read_after_write_new", 16'd0, 16'h5555);

      // IO registers
      wr(A_LED, 16'h0003);
      check("leds_after_write", 32'(leds), 32'h3);
      rd("led_readback", A_LED, 16'h0003);
      wr(16'h100F, 16'hBEEF);
      rd("gp15_readback", 16'h100F, 16'hBEEF);
      wr(A_LEVEL, 16'hFFFF);
      rd("level_write_ignored", A_LEVEL, 16'h0000);
      wr(16'h1010, 16'h7777);
      rd("io_past_end_none", 16'h1010, 16'h0000);
      wr(16'h2000, 16'h7777);
      rd("unmapped_none", 16'h2000, 16'h0000);
      rd("ram_unharmed", 16'd3839, 16'h1234);

      // 5-cycle glitch on button[0]
      button = 2'b01;
      repeat (5) tick();
      button = 2'b00;
      repeat (LAT + 4) tick();
      rd("glitch_level", A_LEVEL, 16'h0000);
`ifdef MEMIO_DEBOUNCE_EN
      rd("glitch_edge", A_EDGE, 16'h0000);
`else
      rd("glitch_edge", A_EDGE, 16'h0001);
`endif
      wr(A_EDGE, 16'hFFFF);
      rd("edge_clear_all", A_EDGE, 16'h0000);

      // Held press on button[0]: exact latency
      button = 2'b01;
      repeat (LAT - 1) tick();
      rd("hold_level_early", A_LEVEL, 16'h0000);
      rd("hold_edge_early", A_EDGE, 16'h0000);
      tick();
      rd("hold_level", A_LEVEL, 16'h0001);
      rd("hold_edge", A_EDGE, 16'h0001);
      repeat (2) tick();
      rd("hold_edge_sticky", A_EDGE, 16'h0001);

      // W1C on two flags
      button = 2'b11;
      repeat (LAT + 1) tick();
      rd("both_level", A_LEVEL, 16'h0003);
      rd("both_edge", A_EDGE, 16'h0003);
      wr(A_EDGE, 16'h0001);
      rd("w1c_bit0", A_EDGE, 16'h0002);
      wr(A_EDGE, 16'hFFFF);
      rd("w1c_all", A_EDGE, 16'h0000);

      // Release button[1]: falling level sets no flag
      button = 2'b01;
      repeat (LAT + 1) tick();
      rd("fall_level", A_LEVEL, 16'h0001);
      rd("fall_edge", A_EDGE, 16'h0000);

      // Clear of bit 1 coincides with its rise: set wins
      button = 2'b11;
      repeat (LAT - 1) tick();
      rd("coll_level_before", A_LEVEL, 16'h0001);
      wr(A_EDGE, 16'h0002);
      rd("coll_level_after", A_LEVEL, 16'h0003);
      rd("coll_edge_set_wins", A_EDGE, 16'h0002);
      wr(A_EDGE, 16'h0002);
      rd("coll_then_clear", A_EDGE, 16'h0000);

      // Reset mid-debounce on button[1]
      button = 2'b01;
      repeat (LAT + 1) tick();
      rd("pre_rst_level", A_LEVEL, 16'h0001);
      wr(A_EDGE, 16'hFFFF);
      button = 2'b11;
      repeat (6) tick();
      addressM = A_LEVEL;
      rst_n    = 1'b0;
      #1;
      check("rst_level_cleared", 32'(inM), 32'h0);
      check("rst_leds_cleared", 32'(leds), 32'h0);
      tick();
      rst_n = 1'b1;
      rd("rst_gp15_cleared", 16'h100F, 16'h0000);
      rd("rst_ram_kept", 16'd3839, 16'h1234);
      repeat (LAT - 1) tick();
      rd("rst_level_early", A_LEVEL, 16'h0000);
      tick();
      rd("rst_level_full", A_LEVEL, 16'h0003);
      rd("rst_edge_full", A_EDGE, 16'h0003);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
